// File: rtl/door_input_conditioner_pkg.sv
// Shared defaults and channel map for the garage-door input front-end.
// The controller bench imports the same defaults so both agree on timing.
package door_input_conditioner_pkg;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Filter channel indices inside the conditioner
    localparam int CH_BTN  = 0;
    localparam int CH_UP   = 1;
    localparam int CH_DOWN = 2;
    localparam int NUM_CH  = 3;

    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/door_input_conditioner_debounce_filter.sv
// One input channel: synchroniser chain followed by a disagreement-count debouncer.
// The stable value only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_filter
    import door_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic Raw_In,
    output logic Stable_Out
);

    localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_last;
    logic                   stable_reg;
    logic                   stable_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (!RST) sync_reg[gi] <= 1'b0;
                    else      sync_reg[gi] <= Raw_In;
                end
            end else begin : g_next
                always_ff @(posedge CLK) begin
                    if (!RST) sync_reg[gi] <= 1'b0;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_last = sync_reg[SYNC_STAGES-1];

    // Counter only advances while the sample disagrees; it is cleared on flip, so it cannot wrap
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        if (sync_last != stable_reg) begin
            if (cnt_reg == CNT_MAX) stable_next = sync_last;
            else                    cnt_next    = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign Stable_Out = stable_reg;

endmodule

// File: rtl/door_input_conditioner.sv
// Garage-door input front-end: debounced button press pulse, limit levels and limit-fault flag.
// Holds only the arm/edge/fault logic; per-channel filtering lives in debounce_filter.
module door_input_conditioner
    import door_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic Btn_Raw,
    input  logic Up_Lim_Raw,
    input  logic Down_Lim_Raw,
    output logic Activate,
    output logic Up_Max,
    output logic Down_Max,
    output logic Lim_Fault
);

    // Cycles after reset until the button filter has had a chance to reflect a held button
    localparam int PRIME_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);

    logic [NUM_CH-1:0]  raw_vec;
    logic [NUM_CH-1:0]  stable_vec;
    logic               btn_stable;
    logic               btn_d_reg;
    logic               armed_reg;
    logic               armed_next;
    logic [PRIME_W-1:0] prime_cnt_reg;
    logic [PRIME_W-1:0] prime_cnt_next;
    logic               primed;

    assign raw_vec[CH_BTN]  = Btn_Raw;
    assign raw_vec[CH_UP]   = Up_Lim_Raw;
    assign raw_vec[CH_DOWN] = Down_Lim_Raw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_filter #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filter (
                .CLK        (CLK),
                .RST        (RST),
                .Raw_In     (raw_vec[gi]),
                .Stable_Out (stable_vec[gi])
            );
        end
    endgenerate

    assign btn_stable = stable_vec[CH_BTN];
    assign primed     = (prime_cnt_reg == PRIME_DONE);

    // A released button must be observed once the filter is trustworthy before presses count
    always_comb begin
        prime_cnt_next = prime_cnt_reg;
        if (!primed) prime_cnt_next = prime_cnt_reg + PRIME_W'(1);
        armed_next = armed_reg | (primed & ~btn_stable);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            btn_d_reg     <= 1'b0;
            armed_reg     <= 1'b0;
            prime_cnt_reg <= '0;
        end else begin
            btn_d_reg     <= btn_stable;
            armed_reg     <= armed_next;
            prime_cnt_reg <= prime_cnt_next;
        end
    end

    assign Up_Max    = stable_vec[CH_UP];
    assign Down_Max  = stable_vec[CH_DOWN];
    assign Lim_Fault = Up_Max & Down_Max;
    assign Activate  = btn_stable & ~btn_d_reg & armed_reg & ~Lim_Fault;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Directed bench for door_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_door_input_conditioner;

    logic CLK;
    logic RST;
    logic Btn_Raw;
    logic Up_Lim_Raw;
    logic Down_Lim_Raw;
    logic Activate;
    logic Up_Max;
    logic Down_Max;
    logic Lim_Fault;

    int errors = 0;
    int checks = 0;
    int pulses;

    door_input_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Btn_Raw      (Btn_Raw),
        .Up_Lim_Raw   (Up_Lim_Raw),
        .Down_Lim_Raw (Down_Lim_Raw),
        .Activate     (Activate),
        .Up_Max       (Up_Max),
        .Down_Max     (Down_Max),
        .Lim_Fault    (Lim_Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int k);
        repeat (k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic count_pulses(input int k, output int n);
        n = 0;
        repeat (k) begin
            @(posedge CLK);
            #1;
            if (Activate === 1'b1) n++;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
        $display("check %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        RST = 1'b0;
        Btn_Raw = 1'b0;
        Up_Lim_Raw = 1'b0;
        Down_Lim_Raw = 1'b0;
        step(2);
        check("rst_activate", Activate, 1'b0);
        check("rst_up_max", Up_Max, 1'b0);
        check("rst_down_max", Down_Max, 1'b0);
        check("rst_lim_fault", Lim_Fault, 1'b0);
        RST = 1'b1;
        step(10);

        // 1: clean press, pulse in the cycle after edge n+6, no pulse on release
        Btn_Raw = 1'b1;
        step(5);
        check("t1_act_before", Activate, 1'b0);
        step(1);
        check("t1_act_pulse", Activate, 1'b1);
        step(1);
        check("t1_act_after", Activate, 1'b0);
        Btn_Raw = 1'b0;
        count_pulses(10, pulses);
        check_int("t1_release_pulses", pulses, 0);

        // 2: bounce every 2 cycles never debounces
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            Btn_Raw = ((i / 2) % 2) == 0;
            @(posedge CLK);
            #1;
            if (Activate === 1'b1) pulses++;
        end
        Btn_Raw = 1'b0;
        begin
            int tail;
            count_pulses(10, tail);
            pulses += tail;
        end
        check_int("t2_bounce_pulses", pulses, 0);

        // 3: held through reset gives no pulse; later re-press gives one
        Btn_Raw = 1'b1;
        RST = 1'b0;
        step(2);
        RST = 1'b1;
        count_pulses(14, pulses);
        check_int("t3_held_reset_pulses", pulses, 0);
        Btn_Raw = 1'b0;
        count_pulses(8, pulses);
        check_int("t3_release_pulses", pulses, 0);
        Btn_Raw = 1'b1;
        count_pulses(10, pulses);
        check_int("t3_repress_pulses", pulses, 1);
        Btn_Raw = 1'b0;
        count_pulses(10, pulses);
        check_int("t3_rerelease_pulses", pulses, 0);

        // 4: lower limit latency and short/long drops
        Down_Lim_Raw = 1'b1;
        step(5);
        check("t4_down_before", Down_Max, 1'b0);
        step(1);
        check("t4_down_set", Down_Max, 1'b1);
        check("t4_up_quiet", Up_Max, 1'b0);
        Down_Lim_Raw = 1'b0;
        step(3);
        Down_Lim_Raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t4_short_drop", Down_Max, 1'b1);
        end
        Down_Lim_Raw = 1'b0;
        step(4);
        Down_Lim_Raw = 1'b1;
        step(1);
        check("t4_long_drop_hold", Down_Max, 1'b1);
        step(1);
        check("t4_long_drop_clear", Down_Max, 1'b0);
        step(3);
        check("t4_recover_before", Down_Max, 1'b0);
        step(1);
        check("t4_recover_set", Down_Max, 1'b1);

        // 5: both limits active -> fault, presses dropped and not deferred
        Up_Lim_Raw = 1'b1;
        step(5);
        check("t5_fault_before", Lim_Fault, 1'b0);
        step(1);
        check("t5_fault_set", Lim_Fault, 1'b1);
        check("t5_up_set", Up_Max, 1'b1);
        Btn_Raw = 1'b1;
        count_pulses(10, pulses);
        check_int("t5_press_in_fault", pulses, 0);
        Btn_Raw = 1'b0;
        Up_Lim_Raw = 1'b0;
        count_pulses(10, pulses);
        check_int("t5_no_deferred", pulses, 0);
        check("t5_fault_clear", Lim_Fault, 1'b0);
        check("t5_up_clear", Up_Max, 1'b0);

        // 6: reset mid-debounce discards the partial count
        Down_Lim_Raw = 1'b0;
        step(10);
        check("t6_down_idle", Down_Max, 1'b0);
        Down_Lim_Raw = 1'b1;
        step(4);
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        check("t6_rst_activate", Activate, 1'b0);
        check("t6_rst_up", Up_Max, 1'b0);
        check("t6_rst_down", Down_Max, 1'b0);
        check("t6_rst_fault", Lim_Fault, 1'b0);
        step(1);
        check("t6_no_early_flip", Down_Max, 1'b0);
        step(4);
        check("t6_before_full", Down_Max, 1'b0);
        step(1);
        check("t6_full_latency", Down_Max, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
